// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode/func3 encodings and flag bundle for the RV32I ALU
package alu_pkg;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    typedef struct packed {
        logic carry;
        logic zero;
        logic negative;
        logic overflow;
    } alu_flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I OP/OP-IMM decode, datapath and flags
// ports: op1/op2/imm operands, opcode/func3/func7 decode in; result + flags out
module alu_core
    import alu_pkg::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic [31:0] result,
    output alu_flags_t  flags
);
    logic        is_r, valid, sub, arith, c, v;
    logic [31:0] b, sra;
    logic [32:0] sum, diff;
    logic [4:0]  shamt;
    logic        unused_f7;
    assign unused_f7 = ^{func7[6], func7[4:0]};
    assign is_r  = opcode == OPC_OP;
    assign valid = is_r || opcode == OPC_OP_IMM;
    assign b     = is_r ? op2 : imm;
    assign shamt = b[4:0];
    // ADDI has no subtract form; SRAI carries its arithmetic bit in imm[10]
    assign sub   = is_r && func7[5];
    assign arith = is_r ? func7[5] : imm[10];
    assign sum   = {1'b0, op1} + {1'b0, b};
    // bit 32 of the widened difference is the unsigned borrow
    assign diff  = {1'b0, op1} - {1'b0, b};
    assign sra   = $signed(op1) >>> shamt;
    always_comb begin
        result = '0;
        c = 1'b0;
        v = 1'b0;
        case (func3)
            F3_ADD: begin
                result = sub ? diff[31:0] : sum[31:0];
                c = sub ? diff[32] : sum[32];
                v = sub ? (op1[31] != b[31]) && (diff[31] != op1[31])
                        : (op1[31] == b[31]) && (sum[31] != op1[31]);
            end
            F3_SLL:  result = op1 << shamt;
            F3_SLT:  result = {31'b0, $signed(op1) < $signed(b)};
            F3_SLTU: result = {31'b0, op1 < b};
            F3_XOR:  result = op1 ^ b;
            F3_SR:   result = arith ? sra : op1 >> shamt;
            F3_OR:   result = op1 | b;
            default: result = op1 & b;
        endcase
        if (!valid) begin
            result = '0;
            c = 1'b0;
            v = 1'b0;
        end
    end
    assign flags = '{carry: c, zero: result == '0, negative: result[31], overflow: v};
endmodule

// File: rtl/alu_top.sv
// alu_top: RV32I execute-stage ALU with registered (default) or combinational outputs
// ports: clk, rst_n (async active-low); op1, op2, imm, opcode, func3, func7 in;
//        result_alu, carry_flag, zero_flag, negative_flag, overflow_flag out
// macro: ALU_COMB_OUT_EN removes the output registers (clk/rst_n then unused)
module alu_top
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    output logic [31:0] result_alu,
    output logic        carry_flag,
    output logic        zero_flag,
    output logic        negative_flag,
    output logic        overflow_flag
);
    logic [31:0] res;
    alu_flags_t  fl;
    alu_core u_core (
        .op1(op1), .op2(op2), .imm(imm), .opcode(opcode),
        .func3(func3), .func7(func7), .result(res), .flags(fl)
    );
`ifdef ALU_COMB_OUT_EN
    assign result_alu    = res;
    assign carry_flag    = fl.carry;
    assign zero_flag     = fl.zero;
    assign negative_flag = fl.negative;
    assign overflow_flag = fl.overflow;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_alu    <= '0;
            carry_flag    <= 1'b0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            result_alu    <= res;
            carry_flag    <= fl.carry;
            zero_flag     <= fl.zero;
            negative_flag <= fl.negative;
            overflow_flag <= fl.overflow;
        end
    end
`endif
endmodule

// File: tb/tb_alu_top.sv
// tb_alu_top: scoreboard bench for alu_top, observed word is {result, carry, zero, negative, overflow}
module tb_alu_top;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] op1 = 0, op2 = 0, imm = 0;
    logic [6:0]  opcode = 7'h33, func7 = 0;
    logic [2:0]  func3 = 0;
    logic [31:0] result_alu;
    logic        carry_flag, zero_flag, negative_flag, overflow_flag;
    logic [35:0] sb[$];
    logic [35:0] obs;
    int checks = 0, errors = 0;

    alu_top dut (
        .clk(clk), .rst_n(rst_n), .op1(op1), .op2(op2), .imm(imm),
        .opcode(opcode), .func3(func3), .func7(func7),
        .result_alu(result_alu), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .negative_flag(negative_flag), .overflow_flag(overflow_flag)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] dut_word();
        return {result_alu, carry_flag, zero_flag, negative_flag, overflow_flag};
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // reference: wide signed/unsigned arithmetic with range tests for overflow
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] o2,
            input logic [31:0] im, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        logic [31:0] b, r;
        logic        c, v, rt;
        longint      sa, sb2, s;
        logic [63:0] w;
        if (opc != 7'h33 && opc != 7'h13) return {32'd0, 4'b0100};
        rt = opc == 7'h33;
        b = rt ? o2 : im;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        c = 0;
        v = 0;
        case (f3)
            3'd0: if (rt && f7[5]) begin
                      s = sa - sb2;
                      r = a - b;
                      c = a < b;
                      v = s > 64'sd2147483647 || s < -64'sd2147483648;
                  end else begin
                      w = {32'd0, a} + {32'd0, b};
                      r = w[31:0];
                      c = w[32];
                      s = sa + sb2;
                      v = s > 64'sd2147483647 || s < -64'sd2147483648;
                  end
            3'd1: r = a << b[4:0];
            3'd2: r = (sa < sb2) ? 32'd1 : 32'd0;
            3'd3: r = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (rt ? f7[5] : b[10]) begin
                      w = 64'(sa >>> b[4:0]);
                      r = w[31:0];
                  end else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return {r, c, r == 0, r[31], v};
    endfunction

    task automatic run(input string tag, input logic [6:0] opc, input logic [2:0] f3,
            input logic [6:0] f7, input logic [31:0] a, input logic [31:0] o2, input logic [31:0] im);
        opcode = opc; func3 = f3; func7 = f7; op1 = a; op2 = o2; imm = im;
        sb.push_back(model(a, o2, im, opc, f3, f7));
        @(posedge clk);
        #1;
        obs = dut_word();
        if (sb.size() == 0) check({tag, "_sb_empty"}, obs, 36'hx);
        else check(tag, obs, sb.pop_front());
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset", dut_word(), 36'd0);
        rst_n = 1;
        run("add", 7'h33, 3'd0, 7'h00, 32'd10, 32'd20, 32'd0);
        check("add_spec", obs, {32'd30, 4'b0000});
        run("sub", 7'h33, 3'd0, 7'h20, 32'd10, 32'd20, 32'd0);
        check("sub_spec", obs, {32'hFFFFFFF6, 4'b1010});
        run("add_ovf", 7'h33, 3'd0, 7'h00, 32'h7FFFFFFF, 32'd1, 32'd0);
        check("add_ovf_spec", obs, {32'h80000000, 4'b0011});
        run("add_carry", 7'h33, 3'd0, 7'h00, 32'hFFFFFFFF, 32'd1, 32'd0);
        check("add_carry_spec", obs, {32'd0, 4'b1100});
        run("sub_ovf", 7'h33, 3'd0, 7'h20, 32'h80000000, 32'd1, 32'd0);
        run("addi_nosub", 7'h13, 3'd0, 7'h20, 32'd5, 32'd0, 32'hFFFFFFFF);
        check("addi_spec", obs, {32'd4, 4'b1000});
        run("and", 7'h33, 3'd7, 7'h00, 32'hFF00FF00, 32'h0F0F0F0F, 32'd0);
        check("and_spec", obs[35:4], 36'h0F000F00);
        run("andi", 7'h13, 3'd7, 7'h00, 32'hAAAA5555, 32'd0, 32'h0000FFFF);
        check("andi_spec", obs[35:4], 36'h5555);
        run("ori", 7'h13, 3'd6, 7'h00, 32'h12345678, 32'd0, 32'h0000FF00);
        check("ori_spec", obs[35:4], 36'h1234FF78);
        run("xor", 7'h33, 3'd4, 7'h00, 32'hAAAAAAAA, 32'h55555555, 32'd0);
        run("sll", 7'h33, 3'd1, 7'h00, 32'h11, 32'd2, 32'd0);
        check("sll_spec", obs[35:4], 36'h44);
        run("srl", 7'h33, 3'd5, 7'h00, 32'h80000000, 32'd4, 32'd0);
        check("srl_spec", obs[35:4], 36'h08000000);
        run("sra", 7'h33, 3'd5, 7'h20, 32'hFFFFFFE0, 32'd3, 32'd0);
        check("sra_spec", obs[35:4], 36'hFFFFFFFC);
        run("srai", 7'h13, 3'd5, 7'h00, 32'hFFFFFFE0, 32'd0, 32'h403);
        check("srai_spec", obs[35:4], 36'hFFFFFFFC);
        run("srli", 7'h13, 3'd5, 7'h20, 32'h80000000, 32'd0, 32'd4);
        check("srli_spec", obs[35:4], 36'h08000000);
        run("slt", 7'h33, 3'd2, 7'h00, 32'hFFFFFFFB, 32'd10, 32'd0);
        check("slt_spec", obs[35:4], 36'd1);
        run("slti", 7'h13, 3'd2, 7'h00, 32'hFFFFFFFB, 32'd0, 32'd10);
        run("sltu", 7'h33, 3'd3, 7'h00, 32'hFFFFFF00, 32'h100, 32'd0);
        check("sltu_spec", obs, {32'd0, 4'b0100});
        run("sltiu", 7'h13, 3'd3, 7'h00, 32'hFFFFFF00, 32'd0, 32'h100);
        run("bad_opc", 7'h32, 3'd0, 7'h00, 32'd7, 32'd9, 32'd0);
        check("bad_opc_spec", obs, {32'd0, 4'b0100});
        for (int i = 0; i < 60; i++) begin
            logic [6:0] opc;
            case ($urandom_range(0, 4))
                0, 1: opc = 7'h33;
                2, 3: opc = 7'h13;
                default: opc = 7'($urandom);
            endcase
            run("rand", opc, 3'($urandom), ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                $urandom, $urandom, $urandom);
        end
        run("pre_rst", 7'h33, 3'd6, 7'h00, 32'h1234, 32'h8000_0000, 32'd0);
        #3 rst_n = 0;
        #1 check("async_rst", dut_word(), 36'd0);
        @(posedge clk);
        #2 rst_n = 1;
        run("post_rst", 7'h33, 3'd0, 7'h20, 32'd3, 32'd3, 32'd0);
        check("post_rst_spec", obs, {32'd0, 4'b0100});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
